// File: rtl/alu8_sequencer.sv
// alu8_sequencer: command-driven controller in front of an 8-bit ALU datapath.
// Single-cycle ops (AND/OR/XOR/ADD/SUB, SHL by 0, reserved) complete directly.
// MUL (shift-add) and SHL (n > 0) are sequenced one step per cycle in EXEC.
// Results are returned through a rsp valid/ready handshake and held until taken.
// Optional feature macro: ALU8_SEQ_ERR_EN adds the rsp_err output (flags opcode 111).
module alu8_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_result,
    output logic               rsp_zero,
    output logic               rsp_carry,
    output logic               busy
`ifdef ALU8_SEQ_ERR_EN
    ,
    output logic               rsp_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_ADD = 3'b011,
        OP_SUB = 3'b100,
        OP_MUL = 3'b101,
        OP_SHL = 3'b110,
        OP_RSV = 3'b111
    } op_t;

    state_t             state;
    state_t             state_next;
    op_t                cmd_opc;
    op_t                op_q;

    // Working registers for the multi-cycle sequences.
    logic [2*WIDTH-1:0] acc;       // MUL partial product
    logic [2*WIDTH-1:0] mcand;     // MUL multiplicand, shifted left per step
    logic [WIDTH-1:0]   mplier;    // MUL multiplier, consumed LSB first
    logic [WIDTH-1:0]   shreg;     // SHL operand being shifted
    logic [2:0]         shamt;     // SHL step count
    logic [CNT_W-1:0]   cnt;       // step counter

    logic               accept;
    logic               multi_cycle;
    logic               exec_last;
    logic [2*WIDTH-1:0] alu_result;
    logic               alu_carry;
    logic [WIDTH:0]     alu_wide;
    logic [2*WIDTH-1:0] mul_sum;
    logic [WIDTH-1:0]   shl_next;

    assign cmd_opc     = op_t'(cmd_op);
    assign accept      = cmd_valid && cmd_ready;
    assign multi_cycle = (cmd_opc == OP_MUL) ||
                         ((cmd_opc == OP_SHL) && (cmd_b[2:0] != 3'd0));

    // Single-cycle ALU result and carry/borrow from the presented command.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_wide   = '0;
        case (cmd_opc)
            OP_AND: alu_result = {{WIDTH{1'b0}}, cmd_a & cmd_b};
            OP_OR:  alu_result = {{WIDTH{1'b0}}, cmd_a | cmd_b};
            OP_XOR: alu_result = {{WIDTH{1'b0}}, cmd_a ^ cmd_b};
            OP_ADD: begin
                alu_wide   = {1'b0, cmd_a} + {1'b0, cmd_b};
                alu_result = {{WIDTH{1'b0}}, alu_wide[WIDTH-1:0]};
                alu_carry  = alu_wide[WIDTH];
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is the unsigned borrow.
                alu_wide   = {1'b0, cmd_a} - {1'b0, cmd_b};
                alu_result = {{WIDTH{1'b0}}, alu_wide[WIDTH-1:0]};
                alu_carry  = alu_wide[WIDTH];
            end
            OP_SHL: alu_result = {{WIDTH{1'b0}}, cmd_a};  // only reached with n == 0
            default: begin
                alu_result = '0;                            // MUL is sequenced; reserved yields 0
                alu_carry  = 1'b0;
            end
        endcase
    end

    // Next-step values for the EXEC sequences and detection of the final step.
    always_comb begin
        mul_sum  = acc + (mplier[0] ? mcand : '0);
        shl_next = {shreg[WIDTH-2:0], 1'b0};
        if (op_q == OP_MUL) begin
            exec_last = (cnt == CNT_W'(WIDTH - 1));
        end else begin
            exec_last = (cnt == CNT_W'(shamt - 3'd1));
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    state_next = multi_cycle ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: begin
                busy = 1'b1;
                if (exec_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, step in EXEC, load the held response on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_AND;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            shreg      <= '0;
            shamt      <= '0;
            cnt        <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_carry  <= 1'b0;
        end else if (accept) begin
            op_q   <= cmd_opc;
            shamt  <= cmd_b[2:0];
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, cmd_a};
            mplier <= cmd_b;
            shreg  <= cmd_a;
            if (!multi_cycle) begin
                rsp_result <= alu_result;
                rsp_zero   <= (alu_result == '0);
                rsp_carry  <= alu_carry;
            end
        end else if (state == S_EXEC) begin
            cnt <= cnt + CNT_W'(1);
            if (op_q == OP_MUL) begin
                acc    <= mul_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end else begin
                shreg <= shl_next;
            end
            if (exec_last) begin
                cnt <= '0;
                if (op_q == OP_MUL) begin
                    rsp_result <= mul_sum;
                    rsp_zero   <= (mul_sum == '0);
                    rsp_carry  <= 1'b0;
                end else begin
                    rsp_result <= {{WIDTH{1'b0}}, shl_next};
                    rsp_zero   <= (shl_next == '0);
                    rsp_carry  <= shreg[WIDTH-1];
                end
            end
        end
    end

`ifdef ALU8_SEQ_ERR_EN
    // Error flag for the reserved opcode, held alongside the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if (accept) begin
            rsp_err <= (cmd_opc == OP_RSV);
        end
    end
`endif

endmodule

// File: tb/tb_alu8_sequencer.sv
// Directed self-checking bench for alu8_sequencer.
// Expected values are hand-computed constants in each step.
module tb_alu8_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_carry;
    logic        busy;
`ifdef ALU8_SEQ_ERR_EN
    logic        rsp_err;
`endif

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int lat;
    int bcyc;

    alu8_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_carry  (rsp_carry),
        .busy       (busy)
`ifdef ALU8_SEQ_ERR_EN
        ,
        .rsp_err    (rsp_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command at the falling edge; it is accepted on the next rising edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        check("cmd_ready before accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Latency 1 means rsp_valid is already high just after the accept edge.
    task automatic wait_rsp(output int l, output int bc);
        l  = 1;
        bc = 0;
        while (!rsp_valid && l < 40) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic release_rsp(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, " back to idle"}, {rsp_valid, cmd_ready}, 2'b01);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp_res,
                       input logic exp_zero, input logic exp_carry, input int exp_lat);
        issue(op, a, b);
        wait_rsp(lat, bcyc);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, rsp_result, exp_res);
        check({tag, " zero"}, rsp_zero, exp_zero);
        check({tag, " carry"}, rsp_carry, exp_carry);
`ifdef ALU8_SEQ_ERR_EN
        check({tag, " err"}, rsp_err, (op == 3'b111));
`endif
        release_rsp(tag);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        rsp_ready = 1'b0;

        // Reset state.
        #12;
        check("reset rsp_valid", rsp_valid, 0);
        check("reset busy", busy, 0);
        check("reset cmd_ready", cmd_ready, 0);
        check("reset result", rsp_result, 16'h0000);
        check("reset zero", rsp_zero, 0);
        check("reset carry", rsp_carry, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("cmd_ready after reset", cmd_ready, 1);

        // Single-cycle ops.
        run("xor",  3'b010, 8'hF0, 8'h3C, 16'h00CC, 1'b0, 1'b0, 1);
        run("and",  3'b000, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0, 1);
        run("or",   3'b001, 8'hF0, 8'h3C, 16'h00FC, 1'b0, 1'b0, 1);
        run("add",  3'b011, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b1, 1);
        run("sub",  3'b100, 8'h05, 8'h07, 16'h00FE, 1'b0, 1'b1, 1);
        run("rsv",  3'b111, 8'h12, 8'h34, 16'h0000, 1'b1, 1'b0, 1);

        // Multiply: 8 busy cycles, valid 9 cycles after accept.
        issue(3'b101, 8'hFF, 8'hFF);
        wait_rsp(lat, bcyc);
        check("mul ff busy cycles", bcyc, 8);
        check("mul ff latency", lat, 9);
        check("mul ff result", rsp_result, 16'hFE01);
        check("mul ff zero", rsp_zero, 0);
        check("mul ff carry", rsp_carry, 0);
        check("mul ff busy in done", busy, 0);
        release_rsp("mul ff");
        run("mul zero", 3'b101, 8'h00, 8'h37, 16'h0000, 1'b1, 1'b0, 9);

        // Shift left.
        run("shl 1", 3'b110, 8'h81, 8'h01, 16'h0002, 1'b0, 1'b1, 2);
        run("shl 3", 3'b110, 8'h81, 8'h03, 16'h0008, 1'b0, 1'b0, 4);
        run("shl 0", 3'b110, 8'h81, 8'h00, 16'h0081, 1'b0, 1'b0, 1);

        // Backpressure: result held, new commands refused.
        issue(3'b011, 8'h7F, 8'h01);
        wait_rsp(lat, bcyc);
        check("bp add latency", lat, 1);
        check("bp add carry", rsp_carry, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_op    = 3'b010;
            cmd_a     = 8'(i + 1);
            cmd_b     = 8'h00;
            check("bp result held", rsp_result, 16'h0080);
            check("bp valid held", rsp_valid, 1);
            check("bp cmd_ready low", cmd_ready, 0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp result after stall", rsp_result, 16'h0080);
        check("bp zero after stall", rsp_zero, 0);
        release_rsp("bp");
        @(posedge clk);
        #1;
        check("bp no stray accept", rsp_valid, 0);

        // Reset during a multiply aborts immediately.
        issue(3'b101, 8'h0F, 8'h0F);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("mid-mul busy", busy, 1);
        rst = 1'b1;
        #1;
        check("abort rsp_valid", rsp_valid, 0);
        check("abort busy", busy, 0);
        check("abort cmd_ready", cmd_ready, 0);
        check("abort result cleared", rsp_result, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-abort cmd_ready", cmd_ready, 1);
        run("post-abort xor", 3'b010, 8'h55, 8'hFF, 16'h00AA, 1'b0, 1'b0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu8_sequencer.md
Name: alu8_sequencer

Overview:
- Command-driven controller in front of the 8-bit ALU datapath (AND/OR/XOR/ADD/SUB units).
- Accepts one operation per valid/ready handshake and issues single-cycle ops directly.
- Sequences multi-cycle ops (shift-add multiply, iterative shift-left) using an internal step counter.
- Returns the result and flags through a second valid/ready handshake; sits between the instruction decoder and the register writeback.

Parameters:
- WIDTH, 8, operand width in bits; result is 2*WIDTH.
- CNT_W, 4, step-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL, 110 SHL, 111 reserved
- cmd_a  input  WIDTH  operand A
- cmd_b  input  WIDTH  operand B; for SHL, cmd_b[2:0] is the shift count
- rsp_valid  output  1  result present
- rsp_ready  input  1  consumer accepts result
- rsp_result  output  2*WIDTH  result, zero-extended unless MUL
- rsp_zero  output  1  rsp_result == 0 over all 2*WIDTH bits
- rsp_carry  output  1  ADD carry-out / SUB borrow / SHL last bit shifted out; 0 otherwise
- busy  output  1  state is EXEC

Behaviour:
- Reset (async, active-high) values: state IDLE, rsp_valid 0, rsp_result 0, rsp_zero 0, rsp_carry 0, busy 0, counter 0. cmd_ready is 0 while rst is high.
- Reset asserted mid-operation aborts immediately; the in-flight result is discarded and not replayed.
- States: IDLE, EXEC, DONE. cmd_ready = (state == IDLE) and not rst.
- Accept: cmd_valid and cmd_ready on a rising edge latches cmd_op, cmd_a and cmd_b.
- Single-cycle ops (AND/OR/XOR/ADD/SUB): IDLE -> DONE. rsp_valid rises the cycle after accept (latency 1).
  - ADD: result[WIDTH-1:0] = sum mod 2^WIDTH; carry = bit WIDTH of the sum.
  - SUB: result = (A - B) mod 2^WIDTH; carry = 1 iff A < B (unsigned borrow).
  - Logic ops: carry = 0.
- MUL (unsigned shift-add): IDLE -> EXEC. WIDTH iterations, one multiplier bit per cycle, LSB first. Counter counts 0..WIDTH-1, then EXEC -> DONE. rsp_valid rises WIDTH+1 cycles after accept. carry = 0.
- SHL: n = B[2:0].
  - n == 0: IDLE -> DONE, latency 1, result = A, carry 0.
  - n > 0: EXEC, one bit per cycle for n cycles; rsp_valid at latency n+1. carry = last bit shifted out.
- Result width: upper WIDTH bits of rsp_result are 0 for every op except MUL.
- DONE: rsp_valid = 1. rsp_result, rsp_zero and rsp_carry are held stable until rsp_valid and rsp_ready, then DONE -> IDLE.
- No command is accepted in EXEC or DONE. Next accept is at the earliest the cycle after the response handshake, so there is no overlap.
- Opcode 111: treated as a single-cycle op, result 0, zero 1, carry 0.
- busy = 1 exactly during EXEC cycles.
- Inputs cmd_* are ignored when not accepting. rsp_ready is ignored outside DONE.

Optional Feature:
- Macro: ALU8_SEQ_ERR_EN.
- Defined: adds output rsp_err (1 bit, reset 0). rsp_err = 1 with rsp_valid for opcode 111, and is held with the result in DONE.
- Not defined: port absent; opcode 111 behaves as above with no error indication.

Test Plan:
- XOR A=0xF0, B=0x3C -> rsp_valid 1 cycle after accept; result 0x00CC, zero 0, carry 0.
- ADD A=0xFF, B=0x01 -> result 0x0000, zero 1, carry 1. SUB A=0x05, B=0x07 -> result 0x00FE, carry 1.
- MUL A=0xFF, B=0xFF -> busy high 8 cycles; rsp_valid 9 cycles after accept; result 0xFE01. MUL A=0x00, B=0x37 -> result 0x0000, zero 1.
- SHL A=0x81, B=0x01 -> latency 2, result 0x0002, carry 1. SHL A=0x81, B=0x03 -> latency 4, result 0x0008, carry 0. SHL B=0x00 -> latency 1, result 0x0081.
- Backpressure: hold rsp_ready=0 for 5 cycles after an ADD completes -> rsp_* stable, cmd_ready 0, a new cmd_valid is not accepted. Raise rsp_ready -> IDLE next cycle, cmd_ready 1.
- Assert rst at cycle 4 of a MUL -> rsp_valid and busy 0 immediately. After release, cmd_ready 1 and a new XOR completes normally.
